serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder -- bit-serial two's-complement adder/subtractor.
//
// Takes one operation at a time through a valid/ready handshake, works through
// it one bit per cycle LSB first, then holds the result until it is consumed.
// Subtraction is a + ~b + 1: b is inverted when latched and carry starts at 1.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operation request valid      in_ready   block can accept (registered)
//   a, b       operands (WIDTH bits)         sub        0 = a+b, 1 = a-b
//   out_valid  result valid (registered)     out_ready  consumer accepts result
//   sum        result mod 2^WIDTH            cout       carry out (sub: 1 = no borrow)
//   ovf        signed overflow               busy       state is not IDLE
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  // One extra bit over log2(WIDTH) so the counter never wraps within an op.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_d;
  logic             in_ready_d, out_valid_d;

  logic [WIDTH-1:0] opa, opb;   // latched operands, shifted right each RUN cycle
  logic [WIDTH-1:0] res;        // working result, filled from the MSB end
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_bit, c_next, last;

  // Current bit always sits at position 0 of the shifting operand registers.
  assign s_bit  = opa[0] ^ opb[0] ^ carry;
  assign c_next = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
  assign last   = (cnt == CW'(WIDTH - 1));

  assign busy   = (state != IDLE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // in_ready/out_valid are computed alongside the next state so they can be
  // registered and still line up exactly with the state they describe.
  always_comb begin
    state_d     = state;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_d    = RUN;
          in_ready_d = 1'b0;
        end
      end
      RUN: begin
        if (last) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        // Return to IDLE only; a new op is taken on the following edge.
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= b ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= c_next;
          res   <= {s_bit, res[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          // Published outputs change only here, so they hold through DONE
          // and the following IDLE.
          if (last) begin
            sum  <= {s_bit, res[WIDTH-1:1]};
            cout <= c_next;
            ovf  <= carry ^ c_next;   // carry into MSB vs carry out of MSB
          end
        end
        default: ;
      endcase
    end
  end

endmodule
